// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART TX between A (1 byte) and B (2 bytes, LSB first); grant edge -> tx_valid next cycle.
// Requests stay pending until acked; a byte whose tx_busy never rises drops the rest of the frame (err_timeout).
module uart_tx_scheduler #(
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_a,
  input  logic [7:0]  data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        sched_busy,
  output logic        err_timeout
);

  localparam int TW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_TERM  = TW'(BUSY_TIMEOUT);
  localparam logic [GW-1:0] GAP_TERM = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

  state_t        state_q, state_d;
  grant_t        last_grant_q, last_grant_d;
  logic [15:0]   shift_q, shift_d;
  logic [1:0]    bytes_left_q, bytes_left_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          sched_busy_q, sched_busy_d;
  logic          err_timeout_q, err_timeout_d;
  logic          pick_a;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    shift_d       = shift_q;
    bytes_left_d  = bytes_left_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    err_timeout_d = 1'b0;
    pick_a        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not win last time goes first.
          pick_a = req_a && (!req_b || (last_grant_q == GRANT_B));
          if (pick_a) begin
            shift_d      = {8'h00, data_a};
            bytes_left_d = 2'd1;
            last_grant_d = GRANT_A;
            ack_a_d      = 1'b1;
          end else begin
            shift_d      = data_b;
            bytes_left_d = 2'd2;
            last_grant_d = GRANT_B;
            ack_b_d      = 1'b1;
          end
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          if (to_cnt_q != TO_TERM) to_cnt_d = to_cnt_q + TW'(1);
          if (to_cnt_d == TO_TERM) begin
            err_timeout_d = 1'b1;
            bytes_left_d  = 2'd0;
            state_d       = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (bytes_left_q == 2'd2) begin
            shift_d      = {8'h00, shift_q[15:8]};
            bytes_left_d = 2'd1;
            gap_cnt_d    = '0;
            state_d      = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
          end else begin
            bytes_left_d = 2'd0;
            state_d      = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q != GAP_TERM) gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_d == GAP_TERM) state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase

    // tx_data only changes when a byte is launched, so it holds through the whole UART frame.
    if (state_d == S_SEND) begin
      tx_valid_d = 1'b1;
      tx_data_d  = shift_d[7:0];
    end
    sched_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_B;
      shift_q       <= '0;
      bytes_left_q  <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      sched_busy_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      shift_q       <= shift_d;
      bytes_left_q  <= bytes_left_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      sched_busy_q  <= sched_busy_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign sched_busy  = sched_busy_q;
  assign err_timeout = err_timeout_q;

endmodule
